// File: rtl/data_buf_pkg.sv
// data_buf_pkg
//   Shared types and helpers for the ping-pong row buffer.
//   - bank_st_e         : ownership state of one bank (FREE = producer may
//                         fill it, FULL = consumer may read it).
//   - *_DEF             : default geometry of the buffer.
//   - col_mask_expand() : turns a per-column mask into a per-bit mask.
package data_buf_pkg;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_st_e;

  localparam int MAC_BW_DEF  = 8;
  localparam int COL_CNT_DEF = 16;
  localparam int ROW_CNT_DEF = 16;

  // Upper bounds for the generic mask expander; callers slice the low W bits.
  localparam int MASK_MAX_COLS = 64;
  localparam int MASK_MAX_W    = 1024;

  // Expand mask bit c to bits [c*mac_bw +: mac_bw] of the result.
  function automatic logic [MASK_MAX_W-1:0] col_mask_expand(
    input logic [MASK_MAX_COLS-1:0] mask,
    input int                       mac_bw
  );
    logic [MASK_MAX_W-1:0] r;
    int col;
    r = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      col = i / mac_bw;
      r[i] = (col < MASK_MAX_COLS) ? mask[col[5:0]] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_data_buf_if.sv
// pp_data_buf_if
//   Producer/consumer bus of the ping-pong row buffer.
//   Producer side : wr_en, wr_addr, wr_mask, iData, wr_done  -> buffer
//                   wr_ready                                  <- buffer
//   Consumer side : rd_en, rd_addr, rd_done                   -> buffer
//                   rd_ready, oData, oValid                   <- buffer
//   Handshake: a request (wr_en / wr_done, rd_en / rd_done) takes effect only
//   on a posedge where the matching ready is high; requests while not ready
//   are dropped. oValid is high for exactly the cycle after an accepted rd_en.
//   Modports: master = producer/consumer side, slave = the buffer.
interface pp_data_buf_if #(
  parameter int MAC_BW  = 8,
  parameter int COL_CNT = 16,
  parameter int ROW_CNT = 16,
  parameter int ADDR_BW = $clog2(ROW_CNT)
);
  localparam int W = MAC_BW * COL_CNT;

  logic               wr_en;
  logic [ADDR_BW-1:0] wr_addr;
  logic [COL_CNT-1:0] wr_mask;
  logic [W-1:0]       iData;
  logic               wr_done;
  logic               wr_ready;
  logic               rd_en;
  logic [ADDR_BW-1:0] rd_addr;
  logic               rd_done;
  logic               rd_ready;
  logic [W-1:0]       oData;
  logic               oValid;

  modport master (
    output wr_en, wr_addr, wr_mask, iData, wr_done, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_ready, oData, oValid
  );

  modport slave (
    input  wr_en, wr_addr, wr_mask, iData, wr_done, rd_en, rd_addr, rd_done,
    output wr_ready, rd_ready, oData, oValid
  );
endinterface

// File: rtl/data_buf_bank.sv
// data_buf_bank
//   One row-addressable bank: masked write, registered read.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset (read register only)
//     wr_en      : write row wr_addr, only columns with wr_mask bit set
//     wr_addr    : write row address
//     wr_mask    : per-column write enable
//     wr_data    : write row data
//     rd_en      : load rd_data from row rd_addr on the next edge
//     rd_addr    : read row address
//     rd_data    : registered read data, holds when rd_en is low
module data_buf_bank
  import data_buf_pkg::*;
#(
  parameter int MAC_BW  = MAC_BW_DEF,
  parameter int COL_CNT = COL_CNT_DEF,
  parameter int ROW_CNT = ROW_CNT_DEF,
  parameter int ADDR_BW = $clog2(ROW_CNT),
  parameter int W       = MAC_BW * COL_CNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [COL_CNT-1:0] wr_mask,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [W-1:0]       rd_data
);

  logic [W-1:0] mem [ROW_CNT];

  logic [MASK_MAX_COLS-1:0] mask_wide;
  logic [MASK_MAX_W-1:0]    bit_mask_wide;
  logic [W-1:0]             bit_mask;

  always_comb begin
    mask_wide                = '0;
    mask_wide[COL_CNT-1:0]   = wr_mask;
    bit_mask_wide            = col_mask_expand(mask_wide, MAC_BW);
    bit_mask                 = bit_mask_wide[W-1:0];
  end

  // Storage is deliberately not reset: rows are unobservable until written
  // and handed over to the consumer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= (mem[wr_addr] & ~bit_mask) | (wr_data & bit_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pp_data_buf.sv
// pp_data_buf
//   Ping-pong row buffer between a producer and the SIMD MAC array. The
//   producer fills bank wb while the consumer reads bank rb; ownership of a
//   bank moves on wr_done (FREE -> FULL) and rd_done (FULL -> FREE).
//   Optional feature macro: DATA_BUF_ERR_EN adds sticky err[1:0]
//   (err[0] = producer request while !wr_ready, err[1] = consumer request
//   while !rd_ready).
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     bus         : pp_data_buf_if.slave (write/read/handshake signals)
//     dbg_wb      : write-bank pointer
//     dbg_rb      : read-bank pointer
//     dbg_bank_st : bit i = 1 when bank i is FULL
//     err         : (DATA_BUF_ERR_EN only) sticky protocol error flags
module pp_data_buf
  import data_buf_pkg::*;
#(
  parameter int MAC_BW  = MAC_BW_DEF,
  parameter int COL_CNT = COL_CNT_DEF,
  parameter int ROW_CNT = ROW_CNT_DEF,
  parameter int ADDR_BW = $clog2(ROW_CNT)
) (
  input  logic       clk,
  input  logic       rst_n,
  pp_data_buf_if.slave bus,
  output logic       dbg_wb,
  output logic       dbg_rb,
  output logic [1:0] dbg_bank_st
`ifdef DATA_BUF_ERR_EN
  ,
  output logic [1:0] err
`endif
);

  localparam int W = MAC_BW * COL_CNT;

  bank_st_e bank_st [2];
  logic     wb;
  logic     rb;
  logic     rd_sel;   // bank that produced the most recent read
  logic     o_valid;

  logic     wr_ready;
  logic     rd_ready;
  logic     wr_fire;
  logic     rd_fire;
  logic [W-1:0] bank_rd_data [2];

  assign wr_ready = (bank_st[wb] == FREE);
  assign rd_ready = (bank_st[rb] == FULL);
  assign wr_fire  = bus.wr_en && wr_ready;
  assign rd_fire  = bus.rd_en && rd_ready;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    data_buf_bank #(
      .MAC_BW  (MAC_BW),
      .COL_CNT (COL_CNT),
      .ROW_CNT (ROW_CNT),
      .ADDR_BW (ADDR_BW),
      .W       (W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire && (wb == 1'(i))),
      .wr_addr (bus.wr_addr),
      .wr_mask (bus.wr_mask),
      .wr_data (bus.iData),
      .rd_en   (rd_fire && (rb == 1'(i))),
      .rd_addr (bus.rd_addr),
      .rd_data (bank_rd_data[i])
    );
  end

  // When both handoffs fire together, wb points at a FREE bank and rb at a
  // FULL one, so the two bank_st updates always hit different entries.
  // A write or read in the handoff cycle still uses the old pointer because
  // the bank enables above sample wb/rb before they toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      wb         <= 1'b0;
      rb         <= 1'b0;
      rd_sel     <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= rd_fire;
      if (rd_fire) begin
        rd_sel <= rb;
      end
      if (bus.wr_done && wr_ready) begin
        bank_st[wb] <= FULL;
        wb          <= ~wb;
      end
      if (bus.rd_done && rd_ready) begin
        bank_st[rb] <= FREE;
        rb          <= ~rb;
      end
    end
  end

`ifdef DATA_BUF_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      if ((bus.wr_en || bus.wr_done) && !wr_ready) err[0] <= 1'b1;
      if ((bus.rd_en || bus.rd_done) && !rd_ready) err[1] <= 1'b1;
    end
  end
`endif

  // Each bank's read register holds its last result, so selecting the bank
  // of the latest read gives "oData holds its last value" for free; both
  // registers reset to zero, so oData is zero after reset.
  assign bus.oData    = bank_rd_data[rd_sel];
  assign bus.oValid   = o_valid;
  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;

  assign dbg_wb      = wb;
  assign dbg_rb      = rb;
  assign dbg_bank_st = {bank_st[1] == FULL, bank_st[0] == FULL};

endmodule

// File: tb/tb_pp_data_buf.sv
// tb_pp_data_buf
//   Directed test of the ping-pong row buffer: reset state, empty stall,
//   fill/handoff/read, column masking, simultaneous handoff, full stall and
//   reset in the middle of a read.
module tb_pp_data_buf;
  import data_buf_pkg::*;

  localparam int MAC_BW  = 8;
  localparam int COL_CNT = 16;
  localparam int ROW_CNT = 16;
  localparam int ADDR_BW = 4;
  localparam int W       = MAC_BW * COL_CNT;

  logic       clk;
  logic       rst_n;
  logic       dbg_wb;
  logic       dbg_rb;
  logic [1:0] dbg_bank_st;
`ifdef DATA_BUF_ERR_EN
  logic [1:0] err;
`endif

  int n_pass;
  int n_total;

  pp_data_buf_if #(
    .MAC_BW(MAC_BW), .COL_CNT(COL_CNT), .ROW_CNT(ROW_CNT), .ADDR_BW(ADDR_BW)
  ) bus ();

  pp_data_buf #(
    .MAC_BW(MAC_BW), .COL_CNT(COL_CNT), .ROW_CNT(ROW_CNT), .ADDR_BW(ADDR_BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_wb      (dbg_wb),
    .dbg_rb      (dbg_rb),
    .dbg_bank_st (dbg_bank_st)
`ifdef DATA_BUF_ERR_EN
    ,
    .err         (err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] pat_a(input int row);
    logic [7:0] b;
    b = 8'(row);
    return {16{b}};
  endfunction

  function automatic logic [W-1:0] pat_b(input int row);
    logic [7:0] b;
    b = 8'(row) ^ 8'hA5;
    return {16{b}};
  endfunction

  function automatic logic [W-1:0] pat_c(input int row);
    logic [7:0] b;
    b = 8'(row) + 8'h40;
    return {16{b}};
  endfunction

  // driver tasks
  task automatic write_row(input int addr, input logic [W-1:0] data,
                           input logic [COL_CNT-1:0] mask);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.iData   = data;
    bus.wr_mask = mask;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_mask = '1;
  endtask

  task automatic pulse_wr_done();
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
  endtask

  task automatic pulse_rd_done();
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
  endtask

  // leaves oData/oValid of the accepted read observable on return
  task automatic read_row(input int addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'(addr);
    step();
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] row3_exp;
  logic [W-1:0] hold_exp;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_mask = '1;
    bus.iData   = '0;
    bus.wr_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_done = 1'b0;

    // ---- reset state ----
    do_reset();
    check("rst_ovalid",   W'(bus.oValid),   W'(1'b0));
    check("rst_odata",    bus.oData,        '0);
    check("rst_wr_ready", W'(bus.wr_ready), W'(1'b1));
    check("rst_rd_ready", W'(bus.rd_ready), W'(1'b0));
    check("rst_wb",       W'(dbg_wb),       W'(1'b0));
    check("rst_rb",       W'(dbg_rb),       W'(1'b0));
`ifdef DATA_BUF_ERR_EN
    check("rst_err",      W'(err),          W'(2'b00));
`endif

    // ---- empty stall: read with no FULL bank is dropped ----
    read_row(0);
    check("empty_ovalid", W'(bus.oValid), W'(1'b0));
    check("empty_odata",  bus.oData,      '0);
`ifdef DATA_BUF_ERR_EN
    check("empty_err",    W'(err),        W'(2'b10));
`endif
    do_reset();

    // ---- fill bank0 (row 3 all 0xFF), masked write on row 3, hand over ----
    for (int r = 0; r < ROW_CNT; r++) begin
      write_row(r, (r == 3) ? {W{1'b1}} : pat_a(r), '1);
    end
    write_row(3, '0, 16'h00F0);
    pulse_wr_done();
    check("fill_wr_ready", W'(bus.wr_ready), W'(1'b1));
    check("fill_rd_ready", W'(bus.rd_ready), W'(1'b1));
    check("fill_wb",       W'(dbg_wb),       W'(1'b1));
    check("fill_bank_st",  W'(dbg_bank_st),  W'(2'b01));

    read_row(5);
    check("rd5_ovalid", W'(bus.oValid), W'(1'b1));
    check("rd5_odata",  bus.oData,      pat_a(5));
    step();
    hold_exp = pat_a(5);
    check("rd5_ovalid_drop", W'(bus.oValid), W'(1'b0));
    check("rd5_odata_hold",  bus.oData,      hold_exp);

    row3_exp = {64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    read_row(3);
    check("mask_ovalid", W'(bus.oValid), W'(1'b1));
    check("mask_odata",  bus.oData,      row3_exp);

    // ---- producer fills bank1, then simultaneous wr_done/rd_done ----
    for (int r = 0; r < ROW_CNT; r++) begin
      write_row(r, pat_b(r), '1);
    end
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    check("sim_wb",       W'(dbg_wb),       W'(1'b0));
    check("sim_rb",       W'(dbg_rb),       W'(1'b1));
    check("sim_bank_st",  W'(dbg_bank_st),  W'(2'b10));
    check("sim_wr_ready", W'(bus.wr_ready), W'(1'b1));
    check("sim_rd_ready", W'(bus.rd_ready), W'(1'b1));

    read_row(7);
    check("b1_rd7_odata", bus.oData, pat_b(7));

    // ---- full stall: fill bank0 too, then a dropped write + wr_done ----
    for (int r = 0; r < ROW_CNT; r++) begin
      write_row(r, pat_c(r), '1);
    end
    pulse_wr_done();
    check("full_wr_ready", W'(bus.wr_ready), W'(1'b0));
    check("full_bank_st",  W'(dbg_bank_st),  W'(2'b11));
    bus.wr_en   = 1'b1;
    bus.wr_done = 1'b1;
    bus.wr_addr = '0;
    bus.iData   = {W{1'b1}};
    bus.wr_mask = '1;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_done = 1'b0;
    check("full_wb_stuck", W'(dbg_wb),      W'(1'b1));
    check("full_st_stuck", W'(dbg_bank_st), W'(2'b11));
`ifdef DATA_BUF_ERR_EN
    check("full_err0",     W'(err[0]),      W'(1'b1));
`endif
    // the dropped write targeted bank1, which is the current read bank
    read_row(0);
    check("full_b1_row0", bus.oData, pat_b(0));
    pulse_rd_done();
    check("drain_rb",       W'(dbg_rb),       W'(1'b0));
    check("drain_wr_ready", W'(bus.wr_ready), W'(1'b1));
    read_row(0);
    check("b0_row0_odata", bus.oData, pat_c(0));
    read_row(15);
    check("b0_row15_odata", bus.oData, pat_c(15));

    // ---- reset in the middle of a read ----
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd2;
    rst_n       = 1'b0;
    step();
    bus.rd_en   = 1'b0;
    check("mid_rst_ovalid",   W'(bus.oValid),   W'(1'b0));
    check("mid_rst_odata",    bus.oData,        '0);
    check("mid_rst_rd_ready", W'(bus.rd_ready), W'(1'b0));
    check("mid_rst_wr_ready", W'(bus.wr_ready), W'(1'b1));
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pp_data_buf.md
Name: pp_data_buf

Overview:
- Parametrised ping-pong successor to the single-bank row buffer feeding the SIMD MAC array.
- Two row-addressable banks: the producer fills one bank while the MAC array reads the other.
- Bank ownership passes by a done/ready handshake on each side.
- Adds per-column write masking and a registered read port with a valid flag.

Parameters:
- MAC_BW, 8, bits per column element.
- COL_CNT, 16, columns per row; row width W = MAC_BW*COL_CNT.
- ROW_CNT, 16, rows per bank.
- ADDR_BW, $clog2(ROW_CNT), row address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset (sampled on posedge clk).
- wr_en  in  1  write the row at wr_addr in the current write bank.
- wr_addr  in  ADDR_BW  write row address.
- wr_mask  in  COL_CNT  per-column write enable; bit c covers data bits [c*MAC_BW +: MAC_BW].
- iData  in  W  write row data.
- wr_done  in  1  producer finished the current write bank.
- wr_ready  out  1  the current write bank is FREE.
- rd_en  in  1  read the row at rd_addr in the current read bank.
- rd_addr  in  ADDR_BW  read row address.
- rd_done  in  1  consumer finished the current read bank.
- rd_ready  out  1  the current read bank is FULL.
- oData  out  W  registered read data.
- oValid  out  1  oData holds a valid read result this cycle.

Behaviour:
- State:
  - bank_st[1:0], each FREE or FULL.
  - Write-bank pointer wb and read-bank pointer rb, 1 bit each.
  - Memory mem[2][ROW_CNT] of W bits.
- Reset (rst_n=0 at posedge):
  - Both banks FREE; wb=rb=0.
  - oData=0, oValid=0; error flags cleared.
  - Memory contents are not reset; they are unobservable until written and handed over.
- Outputs: wr_ready = (bank_st[wb]==FREE); rd_ready = (bank_st[rb]==FULL). Both combinational from registers.
- Write:
  - When wr_en && wr_ready, update only the columns whose wr_mask bit is 1: mem[wb][wr_addr] columns take iData.
  - Unmasked columns keep their value.
  - A write while !wr_ready is dropped.
- Write handoff: when wr_done && wr_ready, bank_st[wb] becomes FULL and wb toggles. A wr_en in the same cycle is applied to the old bank first.
- Read:
  - When rd_en && rd_ready, oData takes mem[rb][rd_addr] on the next edge and oValid=1 that cycle. Latency is 1 cycle.
  - Otherwise oValid=0 and oData holds its last value.
- Read handoff: when rd_done && rd_ready, bank_st[rb] becomes FREE and rb toggles. A rd_en in the same cycle reads the old bank.
- Simultaneous wr_done and rd_done are both honoured. wb and rb point at banks in different states, so they never collide.
- Full/empty:
  - Both FULL: wr_ready=0 and the producer stalls.
  - Both FREE: rd_ready=0 and the consumer stalls.
- Same-bank read/write is impossible by construction. No forwarding path exists.
- Reset mid-transfer: all handshake state is lost. Banks return to FREE, and any data in flight is discarded.

Optional Feature:
- Macro: DATA_BUF_ERR_EN.
- Defined:
  - Adds output err[1:0], sticky until reset.
  - err[0] sets on wr_en or wr_done while !wr_ready.
  - err[1] sets on rd_en or rd_done while !rd_ready.
- Undefined: the err port and its logic are absent. Illegal requests are silently ignored, as described above.

Decomposition:
- Shared package data_buf_pkg:
  - typedef bank_st_e {FREE, FULL}.
  - Default MAC_BW/COL_CNT/ROW_CNT constants.
  - Function col_mask_expand(COL_CNT to W bits).
- One sub-module, data_buf_bank: a single masked-write, registered-read row memory.
- Instantiate it twice. The top keeps the pointers, bank state and output mux.

Test Plan:
- Fill and hand over:
  - Reset, write rows 0..15 of bank0 with data = row*0x0101 replicated and mask all-ones, pulse wr_done.
  - Expect wr_ready=1 (bank1 free) and rd_ready=1.
  - rd_en rd_addr=5 gives oData = 0x0505 pattern with oValid=1 exactly one cycle later.
- Mask:
  - Write row 3 with all 0xFF, then write 0x00 with wr_mask=16'h00F0.
  - After handoff, a read of row 3 shows columns 4..7 = 0x00 and all others = 0xFF.
- Full stall:
  - Fill and wr_done both banks without reading: wr_ready=0.
  - A further wr_en to row 0 leaves the data unchanged (verify after rd_done cycles); with DATA_BUF_ERR_EN, err[0]=1.
- Empty stall:
  - After reset, rd_en at addr 0 gives oValid=0 and oData=0; with DATA_BUF_ERR_EN, err[1]=1.
- Simultaneous handoff:
  - Bank0 FULL with rb=0, producer filling bank1.
  - Assert wr_done and rd_done in the same cycle: next cycle bank1 FULL, bank0 FREE, wb=0, rb=1, and wr_ready=rd_ready=1.
- Reset mid-operation:
  - Assert rst_n=0 for one cycle while bank0 is FULL and a read is pending.
  - Next cycle oValid=0, oData=0, rd_ready=0, wr_ready=1.
